// File: rtl/alu_op_sequencer_if.sv
// alu_op_sequencer_if: host command/response handshake bundle
interface alu_op_sequencer_if #(
    parameter int WIDTH = 8,
    parameter int OPW = 3
);
    logic cmd_valid, cmd_ready, cmd_load;
    logic [OPW-1:0] cmd_op;
    logic [WIDTH-1:0] cmd_b;
    logic rsp_valid, rsp_ready, rsp_carry, rsp_zero;
    logic [WIDTH-1:0] rsp_result;
    modport master (
        output cmd_valid, cmd_load, cmd_op, cmd_b, rsp_ready,
        input cmd_ready, rsp_valid, rsp_result, rsp_carry, rsp_zero
    );
    modport slave (
        input cmd_valid, cmd_load, cmd_op, cmd_b, rsp_ready,
        output cmd_ready, rsp_valid, rsp_result, rsp_carry, rsp_zero
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: accumulator-based command driver for a combinational ALU
module alu_op_sequencer #(
    parameter int WIDTH = 8,
    parameter int OPW = 3
) (
    input  logic             clk,
    input  logic             rst,
    alu_op_sequencer_if.slave bus,
    output logic [15:0]      op_count,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_s,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_carry
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t state, state_n;
    logic [WIDTH-1:0] acc;
    logic accept;
    always_ff @(posedge clk) state <= rst ? IDLE : state_n;
    always_comb begin
        bus.cmd_ready = state == IDLE && !rst;
        bus.rsp_valid = state == RESP;
        accept = bus.cmd_valid && bus.cmd_ready;
        state_n = state;
        state_n = (state == IDLE && accept) ? (bus.cmd_load ? RESP : EXEC) :
                  state == EXEC ? RESP :
                  (state == RESP && bus.rsp_ready) ? IDLE : state;
    end
    // rsp_valid is the RESP state itself, so only the payload needs registering
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
            alu_a <= '0;
            alu_b <= '0;
            alu_s <= '0;
            bus.rsp_result <= '0;
            bus.rsp_carry <= 1'b0;
            bus.rsp_zero <= 1'b1;
            op_count <= '0;
        end else begin
            if (accept && !bus.cmd_load) begin
                alu_a <= acc;
                alu_b <= bus.cmd_b;
                alu_s <= bus.cmd_op;
            end
            if (accept && bus.cmd_load) begin
                acc <= bus.cmd_b;
                bus.rsp_result <= bus.cmd_b;
                bus.rsp_carry <= 1'b0;
                bus.rsp_zero <= bus.cmd_b == '0;
            end
            if (state == EXEC) begin
                acc <= alu_result;
                bus.rsp_result <= alu_result;
                bus.rsp_carry <= alu_carry;
                bus.rsp_zero <= alu_result == '0;
                op_count <= op_count + {15'd0, ~&op_count};
            end
        end
    end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed + random commands against an accumulator reference model
module tb_alu_op_sequencer;
    logic clk = 1'b0;
    logic rst;
    logic [15:0] op_count;
    logic [7:0] alu_a, alu_b, alu_result;
    logic [2:0] alu_s;
    logic alu_carry;
    int total = 0;
    int bad = 0;
    logic [7:0] m_acc, m_a, m_b;
    logic [2:0] m_s;
    logic [15:0] m_cnt;

    alu_op_sequencer_if #(.WIDTH(8), .OPW(3)) bus ();

    alu_op_sequencer #(.WIDTH(8), .OPW(3)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .op_count(op_count),
        .alu_a(alu_a),
        .alu_b(alu_b),
        .alu_s(alu_s),
        .alu_result(alu_result),
        .alu_carry(alu_carry)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] alu_fn(input logic [7:0] a, input logic [2:0] s, input logic [7:0] b);
        case (s)
            3'd0: return {1'b0, a} + {1'b0, b};
            3'd1: return {1'b0, a} - {1'b0, b};
            3'd2: return {1'b0, a} + 9'd1;
            3'd3: return {1'b0, a} - 9'd1;
            3'd4: return {1'b0, a & b};
            3'd5: return {1'b0, a | b};
            3'd6: return {1'b0, ~a};
            default: return {1'b0, a ^ b};
        endcase
    endfunction

    always_comb {alu_carry, alu_result} = alu_fn(alu_a, alu_s, alu_b);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_acc = 8'h00;
        m_a = 8'h00;
        m_b = 8'h00;
        m_s = 3'd0;
        m_cnt = 16'h0000;
    endtask

    // Issue one command, check latency/payload, stall the response, then hand it shake.
    task automatic send(input logic ld, input logic [2:0] op, input logic [7:0] b,
                        input int stall, input bit nxt, input bit immediate);
        logic [8:0] r;
        int n;
        n = 0;
        bus.cmd_load = ld;
        bus.cmd_op = op;
        bus.cmd_b = b;
        bus.cmd_valid = 1'b1;
        while (!bus.cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("accept_timeout", 32'(n < 20), 32'd1);
        if (immediate) chk("accept_after_handshake", n, 0);
        r = ld ? {1'b0, b} : alu_fn(m_acc, op, b);
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.cmd_b = 8'($urandom);
        bus.cmd_op = 3'($urandom);
        bus.cmd_load = 1'($urandom);
        bus.rsp_ready = 1'b0;
        if (!ld) begin
            m_a = m_acc;
            m_b = b;
            m_s = op;
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            chk("exec_rsp_valid", bus.rsp_valid, 1'b0);
            chk("exec_cmd_ready", bus.cmd_ready, 1'b0);
            chk("exec_alu_a", alu_a, m_a);
            chk("exec_alu_b", alu_b, m_b);
            chk("exec_alu_s", alu_s, m_s);
            @(negedge clk);
        end
        m_acc = r[7:0];
        chk("rsp_valid", bus.rsp_valid, 1'b1);
        chk("rsp_result", bus.rsp_result, r[7:0]);
        chk("rsp_carry", bus.rsp_carry, r[8]);
        chk("rsp_zero", bus.rsp_zero, 32'(r[7:0] == 8'h00));
        chk("op_count", op_count, m_cnt);
        chk("resp_cmd_ready", bus.cmd_ready, 1'b0);
        for (int i = 0; i < stall; i++) begin
            if (nxt) begin
                bus.cmd_valid = 1'b1;
                bus.cmd_load = 1'b0;
                bus.cmd_op = 3'd0;
                bus.cmd_b = 8'h01;
            end
            @(negedge clk);
            chk("hold_valid", bus.rsp_valid, 1'b1);
            chk("hold_result", bus.rsp_result, r[7:0]);
            chk("hold_carry", bus.rsp_carry, r[8]);
            chk("hold_cmd_ready", bus.cmd_ready, 1'b0);
            chk("hold_alu_b", alu_b, m_b);
            chk("hold_alu_s", alu_s, m_s);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        chk("rsp_drop", bus.rsp_valid, 1'b0);
        chk("idle_cmd_ready", bus.cmd_ready, 1'b1);
    endtask

    initial begin
        rst = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_load = 1'b0;
        bus.cmd_op = 3'd0;
        bus.cmd_b = 8'h00;
        bus.rsp_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_cmd_ready", bus.cmd_ready, 1'b0);
        chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
        chk("rst_rsp_result", bus.rsp_result, 8'h00);
        chk("rst_rsp_carry", bus.rsp_carry, 1'b0);
        chk("rst_rsp_zero", bus.rsp_zero, 1'b1);
        chk("rst_op_count", op_count, 16'h0000);
        chk("rst_alu", {alu_a, alu_b, 5'd0, alu_s}, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        // basic load/ADD/SUB/DEC flow
        send(1'b1, 3'd0, 8'h10, 0, 1'b0, 1'b1);
        send(1'b0, 3'd0, 8'hF5, 1, 1'b0, 1'b1);
        send(1'b0, 3'd1, 8'h05, 0, 1'b0, 1'b1);
        send(1'b0, 3'd3, 8'h77, 2, 1'b0, 1'b1);
        // backpressure with a pending command waiting behind the response
        send(1'b0, 3'd2, 8'h00, 3, 1'b1, 1'b1);
        send(1'b0, 3'd0, 8'h01, 0, 1'b0, 1'b1);
        // reset during EXEC aborts the XOR
        bus.cmd_load = 1'b0;
        bus.cmd_op = 3'd7;
        bus.cmd_b = 8'hAA;
        bus.cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        chk("abort_exec_s", alu_s, 3'd7);
        chk("abort_exec_b", alu_b, 8'hAA);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_cmd_ready", bus.cmd_ready, 1'b0);
        chk("abort_rsp_valid", bus.rsp_valid, 1'b0);
        chk("abort_alu", {alu_a, alu_b, 5'd0, alu_s}, 32'h0);
        chk("abort_op_count", op_count, 16'h0000);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        chk("abort_no_rsp", bus.rsp_valid, 1'b0);
        send(1'b0, 3'd2, 8'h00, 0, 1'b0, 1'b1);
        // saturation from a preloaded counter
        force dut.op_count = 16'hFFFE;
        @(negedge clk);
        release dut.op_count;
        m_cnt = 16'hFFFE;
        @(negedge clk);
        chk("preload_count", op_count, 16'hFFFE);
        send(1'b1, 3'd0, 8'h0F, 0, 1'b0, 1'b1);
        send(1'b0, 3'd4, 8'h3C, 0, 1'b0, 1'b1);
        send(1'b0, 3'd5, 8'h30, 1, 1'b0, 1'b1);
        send(1'b0, 3'd6, 8'h99, 0, 1'b0, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        for (int k = 0; k < 60; k++) begin
            bus.rsp_ready = 1'($urandom);
            @(negedge clk);
            send(1'($urandom_range(0, 3) == 0), 3'($urandom), 8'($urandom),
                 $urandom_range(0, 3), 1'b0, 1'b1);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Command-side driver for the team's 8-bit combinational ALU (opcodes 000 ADD, 001 SUB, 010 INC, 011 DEC, 100 AND, 101 OR, 110 NOT, 111 XOR; outputs result plus carry).
- Takes host commands over a valid/ready handshake and keeps an accumulator as operand A.
- Drives the ALU's a/b/s inputs from registers and captures result/carry back into the accumulator.
- Returns result and flags over a second valid/ready handshake.
- Sits between a host/test controller and one ALU instance.

Parameters:
WIDTH, 8, datapath width of accumulator, operands and result
OPW, 3, opcode width (matches ALU select)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous, active-high reset
cmd_valid  in  1  host command present
cmd_ready  out  1  block accepts command this cycle
cmd_load  in  1  1 = load accumulator with cmd_b, no ALU op
cmd_op  in  OPW  ALU opcode (ignored when cmd_load=1)
cmd_b  in  WIDTH  operand B / load value
rsp_valid  out  1  response present
rsp_ready  in  1  host takes response
rsp_result  out  WIDTH  new accumulator value
rsp_carry  out  1  ALU carry/borrow of this op (0 for load)
rsp_zero  out  1  rsp_result == 0
op_count  out  16  completed ALU ops (loads excluded), saturates at 0xFFFF
alu_a  out  WIDTH  to ALU a (registered)
alu_b  out  WIDTH  to ALU b (registered)
alu_s  out  OPW  to ALU s (registered)
alu_result  in  WIDTH  from ALU
alu_carry  in  1  from ALU

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (rst).
- Reset values:
  - state = IDLE; acc = 0; alu_a, alu_b, alu_s = 0.
  - rsp_valid, rsp_result, rsp_carry = 0; rsp_zero = 1; op_count = 0.
  - cmd_ready = 0 in any cycle where rst = 1.
- Reset mid-operation aborts the operation: no response is produced and the accumulator returns to 0.
- FSM states:
  - IDLE: cmd_ready = 1. On cmd_valid && cmd_ready:
    - cmd_load = 0: latch alu_a <= acc, alu_b <= cmd_b, alu_s <= cmd_op; go to EXEC.
    - cmd_load = 1: acc <= cmd_b; rsp_result <= cmd_b; rsp_carry <= 0; rsp_zero <= (cmd_b == 0); rsp_valid <= 1; go to RESP.
  - EXEC (exactly 1 cycle): ALU inputs are stable for the whole cycle; the combinational ALU settles within it. At the end of the cycle:
    - acc <= alu_result; rsp_result <= alu_result; rsp_carry <= alu_carry; rsp_zero <= (alu_result == 0).
    - rsp_valid <= 1; op_count += 1 unless already 0xFFFF; go to RESP.
  - RESP: hold all rsp_* stable while rsp_valid && !rsp_ready. On rsp_ready: rsp_valid <= 0; go to IDLE.
- cmd_ready = 0 in EXEC and RESP. No overlap: the next command is accepted no earlier than the cycle after the response handshake.
- Latency, with the command accepted at edge T:
  - ALU op: rsp_valid high from edge T+2.
  - Load: rsp_valid high from edge T+1.
- alu_a/b/s hold their last values outside EXEC. They change only on command acceptance.
- Carry is passed through unmodified, i.e. the ALU's bit 8; for SUB/DEC this is the borrow.
- rsp_zero is computed on WIDTH bits only and ignores carry.
- cmd_op/cmd_b are sampled only at the acceptance edge. Changes while cmd_ready = 0 are ignored.
- rsp_ready high while rsp_valid = 0 has no effect.

Test Plan:
1. Reset, then load 0x10 -> rsp_valid 1 cycle after accept; result 0x10, carry 0, zero 0; op_count 0.
2. From acc 0x10, ADD (000) with b=0xF5 -> alu_a=0x10, alu_b=0xF5, alu_s=000 during EXEC; response 2 cycles after accept: result 0x05, carry 1, zero 0; op_count 1.
3. From acc 0x05, SUB (001) with b=0x05 -> result 0x00, carry 0, zero 1. Then DEC (011) -> result 0xFF, carry 1, zero 0.
4. Backpressure: hold rsp_ready low for 3 cycles after rsp_valid, with cmd_valid held high carrying a new op -> rsp_* stable and cmd_ready 0 throughout. The new command is accepted only in the cycle after the rsp handshake.
5. Reset mid-op: accept XOR (111) with b=0xAA, assert rst during EXEC -> no rsp_valid; acc 0, alu_* 0, op_count 0, cmd_ready 0 while rst is high.
6. Saturation: force/preload op_count 0xFFFE, run 3 ops (AND/OR/NOT) -> op_count reads 0xFFFF and stays there. Each op's results match the ALU: acc 0x0F AND 0x3C = 0x0C; OR 0x30 = 0x3C.
